// File: rtl/multi_channel_clock_gate_if.sv
// Control/status bundle between the system controller and multi_channel_clock_gate.
// test_enable exists only when CLOCK_GATE_TEST_MODE_EN is defined.
interface multi_channel_clock_gate_if #(
    parameter int CHANNELS   = 4,
    parameter int IDLE_WIDTH = 8
);
    logic [CHANNELS-1:0]   channel_enable;
    logic [CHANNELS-1:0]   channel_request;
    logic [IDLE_WIDTH-1:0] idle_threshold;
    logic [CHANNELS-1:0]   gated_clocks;
    logic [CHANNELS-1:0]   channel_ready;
    logic                  any_clock_on;
`ifdef CLOCK_GATE_TEST_MODE_EN
    logic                  test_enable;

    modport master (
        output channel_enable, channel_request, idle_threshold, test_enable,
        input  gated_clocks, channel_ready, any_clock_on
    );
    modport slave (
        input  channel_enable, channel_request, idle_threshold, test_enable,
        output gated_clocks, channel_ready, any_clock_on
    );
`else
    modport master (
        output channel_enable, channel_request, idle_threshold,
        input  gated_clocks, channel_ready, any_clock_on
    );
    modport slave (
        input  channel_enable, channel_request, idle_threshold,
        output gated_clocks, channel_ready, any_clock_on
    );
`endif
endinterface

// File: rtl/multi_channel_clock_gate.sv
// Demand-driven per-channel clock gating: OFF/WAKE/ON/HOLD FSM per channel feeding a
// low-transparent latch + AND gate. CLOCK_GATE_TEST_MODE_EN adds a scan force-on input.
module multi_channel_clock_gate #(
    parameter int CHANNELS   = 4,
    parameter int IDLE_WIDTH = 8,
    parameter int WAKE_DELAY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    multi_channel_clock_gate_if.slave bus
);
    localparam int WAKE_W = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;
    localparam logic [WAKE_W-1:0]   WAKE_LAST = WAKE_W'(WAKE_DELAY - 1);
    localparam logic [WAKE_W-1:0]   WAKE_ONE  = WAKE_W'(1);
    localparam logic [IDLE_WIDTH-1:0] IDLE_ONE = IDLE_WIDTH'(1);
    localparam logic [IDLE_WIDTH:0]   IDLE_ONE_X = (IDLE_WIDTH + 1)'(1);

    typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_ON, ST_HOLD} state_e;

    state_e                state_q    [CHANNELS];
    state_e                state_d    [CHANNELS];
    logic [WAKE_W-1:0]     wake_cnt_q [CHANNELS];
    logic [WAKE_W-1:0]     wake_cnt_d [CHANNELS];
    logic [IDLE_WIDTH-1:0] idle_cnt_q [CHANNELS];
    logic [IDLE_WIDTH-1:0] idle_cnt_d [CHANNELS];
    logic [CHANNELS-1:0]   gate_en_q, gate_en_d;
    logic [CHANNELS-1:0]   ready_q, ready_d;
    logic [CHANNELS-1:0]   latch_q, latch_in;
    logic                  armed_q, armed_d;

    always_comb begin
        armed_d = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]    = state_q[i];
            wake_cnt_d[i] = wake_cnt_q[i];
            idle_cnt_d[i] = idle_cnt_q[i];
            if (!bus.channel_enable[i]) begin
                state_d[i] = ST_OFF;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        if (bus.channel_request[i]) begin
                            state_d[i]    = ST_WAKE;
                            wake_cnt_d[i] = '0;
                        end
                    end
                    ST_WAKE: begin
                        // Wake always runs to completion, even if the request drops.
                        wake_cnt_d[i] = wake_cnt_q[i] + WAKE_ONE;
                        if (wake_cnt_q[i] == WAKE_LAST) state_d[i] = ST_ON;
                    end
                    ST_ON: begin
                        if (!bus.channel_request[i]) begin
                            if (bus.idle_threshold == '0) begin
                                state_d[i] = ST_OFF;
                            end else begin
                                state_d[i]    = ST_HOLD;
                                idle_cnt_d[i] = '0;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (bus.channel_request[i]) begin
                            state_d[i] = ST_ON;
                        end else begin
                            if (idle_cnt_q[i] != '1) idle_cnt_d[i] = idle_cnt_q[i] + IDLE_ONE;
                            // Live threshold: lowering it mid-count closes on the next edge.
                            if (({1'b0, idle_cnt_q[i]} + IDLE_ONE_X) >= {1'b0, bus.idle_threshold})
                                state_d[i] = ST_OFF;
                        end
                    end
                    default: state_d[i] = ST_OFF;
                endcase
            end
            gate_en_d[i] = (state_d[i] != ST_OFF);
            ready_d[i]   = (state_d[i] == ST_ON) || (state_d[i] == ST_HOLD);
        end
    end

    // The first edge after reset release only arms the controller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q   <= 1'b0;
            gate_en_q <= '0;
            ready_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]    <= ST_OFF;
                wake_cnt_q[i] <= '0;
                idle_cnt_q[i] <= '0;
            end
        end else begin
            armed_q <= armed_d;
            if (armed_q) begin
                gate_en_q <= gate_en_d;
                ready_q   <= ready_d;
                for (int i = 0; i < CHANNELS; i++) begin
                    state_q[i]    <= state_d[i];
                    wake_cnt_q[i] <= wake_cnt_d[i];
                    idle_cnt_q[i] <= idle_cnt_d[i];
                end
            end
        end
    end

`ifdef CLOCK_GATE_TEST_MODE_EN
    assign latch_in = gate_en_q | {CHANNELS{bus.test_enable}};
`else
    assign latch_in = gate_en_q;
`endif

    // Enable only changes while clk is low, so the AND never sees a partial high phase.
    always_latch begin
        if (!reset)    latch_q <= '0;
        else if (!clk) latch_q <= latch_in;
    end

    assign bus.gated_clocks  = {CHANNELS{clk}} & latch_q;
    assign bus.channel_ready = ready_q;
    assign bus.any_clock_on  = |gate_en_q;
endmodule

// File: tb/tb_multi_channel_clock_gate.sv
// Directed bench for multi_channel_clock_gate (CHANNELS=4, IDLE_WIDTH=8, WAKE_DELAY=2).
`timescale 1ns/1ns
module tb_multi_channel_clock_gate;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    multi_channel_clock_gate_if #(.CHANNELS(4), .IDLE_WIDTH(8)) bus ();

    multi_channel_clock_gate #(.CHANNELS(4), .IDLE_WIDTH(8), .WAKE_DELAY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every high phase of a gated clock must be a full half period (5 ns) unless reset cut it.
    for (genvar g = 0; g < 4; g++) begin : g_pw
        time rise_t = 0;
        always @(posedge bus.gated_clocks[g]) rise_t = $time;
        always @(negedge bus.gated_clocks[g]) begin
            if (reset) begin
                n_cmp++;
                if (($time - rise_t) != 5)
                    begin n_bad++; $display("FAIL pulse_width ch%0d: got %0t want 5", g, $time - rise_t); end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns every channel to OFF and re-enables all of them.
    task automatic settle();
        bus.channel_request = 4'h0;
        bus.channel_enable  = 4'h0;
        step();
        step();
        bus.channel_enable  = 4'hF;
    endtask

    task automatic test_reset();
        step(); step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL rst_gated: got %b want 0000", bus.gated_clocks); end
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", bus.channel_ready); end
        n_cmp++; if (bus.any_clock_on !== 1'b0) begin n_bad++; $display("FAIL rst_any: got %b want 0", bus.any_clock_on); end
        reset = 1'b1;
        bus.channel_enable  = 4'hF;
        bus.channel_request = 4'h1;
        step();
        n_cmp++; if (bus.any_clock_on !== 1'b0) begin n_bad++; $display("FAIL rel_first_edge: got %b want 0", bus.any_clock_on); end
        step();
        n_cmp++; if (bus.any_clock_on !== 1'b1) begin n_bad++; $display("FAIL rel_second_edge: got %b want 1", bus.any_clock_on); end
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL rel_no_pulse: got %b want 0000", bus.gated_clocks); end
        step();
        step();
        n_cmp++; if (bus.channel_ready !== 4'h1) begin n_bad++; $display("FAIL rel_ready: got %b want 0001", bus.channel_ready); end
        @(posedge clk);
        #2;
        n_cmp++; if (bus.gated_clocks !== 4'h1) begin n_bad++; $display("FAIL mid_pulse_pre: got %b want 0001", bus.gated_clocks); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL mid_pulse_gated: got %b want 0000", bus.gated_clocks); end
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL mid_pulse_ready: got %b want 0000", bus.channel_ready); end
        n_cmp++; if (bus.any_clock_on !== 1'b0) begin n_bad++; $display("FAIL mid_pulse_any: got %b want 0", bus.any_clock_on); end
        bus.channel_request = 4'h0;
        bus.channel_enable  = 4'h0;
        step();
        reset = 1'b1;
        step(); step();
        n_cmp++; if ({bus.gated_clocks, bus.channel_ready, bus.any_clock_on} !== 9'h0)
            begin n_bad++; $display("FAIL post_rst_idle: got %b/%b/%b want 0", bus.gated_clocks, bus.channel_ready, bus.any_clock_on); end
        bus.channel_enable = 4'hF;
    endtask

    task automatic test_wake();
        bus.idle_threshold  = 8'd3;
        bus.channel_request = 4'h1;
        step();
        n_cmp++; if (bus.any_clock_on !== 1'b1) begin n_bad++; $display("FAIL wake_any: got %b want 1", bus.any_clock_on); end
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL wake_k: got %b want 0000", bus.gated_clocks); end
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h1) begin n_bad++; $display("FAIL wake_k1_gated: got %b want 0001", bus.gated_clocks); end
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL wake_k1_ready: got %b want 0000", bus.channel_ready); end
        step();
        n_cmp++; if (bus.channel_ready !== 4'h1) begin n_bad++; $display("FAIL wake_k2_ready: got %b want 0001", bus.channel_ready); end
        // ch1 request is only one cycle wide; WAKE must still complete.
        bus.channel_request = 4'h3;
        step();
        bus.channel_request = 4'h1;
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h3) begin n_bad++; $display("FAIL wake_drop_gated: got %b want 0011", bus.gated_clocks); end
        n_cmp++; if (bus.channel_ready !== 4'h1) begin n_bad++; $display("FAIL wake_drop_k1: got %b want 0001", bus.channel_ready); end
        step();
        n_cmp++; if (bus.channel_ready !== 4'h3) begin n_bad++; $display("FAIL wake_drop_k2: got %b want 0011", bus.channel_ready); end
        step();
        n_cmp++; if (bus.channel_ready !== 4'h3) begin n_bad++; $display("FAIL wake_drop_hold: got %b want 0011", bus.channel_ready); end
        settle();
    endtask

    task automatic test_hold_close();
        bus.idle_threshold  = 8'd3;
        bus.channel_request = 4'h1;
        step(); step(); step();
        bus.channel_request = 4'h0;
        step();
        n_cmp++; if (bus.channel_ready[0] !== 1'b1) begin n_bad++; $display("FAIL hold_m_ready: got %b want 1", bus.channel_ready[0]); end
        for (int e = 1; e <= 3; e++) begin
            step();
            n_cmp++; if (bus.gated_clocks !== 4'h1) begin n_bad++; $display("FAIL hold_m%0d_gated: got %b want 0001", e, bus.gated_clocks); end
        end
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL hold_close_ready: got %b want 0000", bus.channel_ready); end
        n_cmp++; if (bus.any_clock_on !== 1'b0) begin n_bad++; $display("FAIL hold_close_any: got %b want 0", bus.any_clock_on); end
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL hold_after_close: got %b want 0000", bus.gated_clocks); end
        settle();
    endtask

    task automatic test_rerequest();
        bus.idle_threshold  = 8'd5;
        bus.channel_request = 4'h1;
        step(); step(); step();
        bus.channel_request = 4'h0;
        for (int e = 0; e < 6; e++) begin
            step();
            if (e == 2) bus.channel_request = 4'h1;
            n_cmp++; if ({bus.gated_clocks[0], bus.channel_ready[0]} !== 2'b11)
                begin n_bad++; $display("FAIL rereq_e%0d: got clk=%b rdy=%b want 1/1", e, bus.gated_clocks[0], bus.channel_ready[0]); end
        end
        settle();
    endtask

    task automatic test_threshold_zero();
        bus.idle_threshold  = 8'd0;
        bus.channel_request = 4'h8;
        step(); step(); step();
        bus.channel_request = 4'h0;
        step();
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL thr0_ready: got %b want 0000", bus.channel_ready); end
        n_cmp++; if (bus.gated_clocks !== 4'h8) begin n_bad++; $display("FAIL thr0_last_edge: got %b want 1000", bus.gated_clocks); end
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL thr0_closed: got %b want 0000", bus.gated_clocks); end
        settle();
    endtask

    task automatic test_live_threshold();
        bus.idle_threshold  = 8'd200;
        bus.channel_request = 4'h2;
        step(); step(); step();
        bus.channel_request = 4'h0;
        step(); step(); step();
        n_cmp++; if (bus.channel_ready !== 4'h2) begin n_bad++; $display("FAIL live_holding: got %b want 0010", bus.channel_ready); end
        bus.idle_threshold = 8'd1;
        step();
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL live_close: got %b want 0000", bus.channel_ready); end
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL live_gated: got %b want 0000", bus.gated_clocks); end
        settle();
    endtask

    task automatic test_forced_off();
        bus.idle_threshold  = 8'd3;
        bus.channel_request = 4'h4;
        step(); step(); step(); step();
        n_cmp++; if (bus.channel_ready !== 4'h4) begin n_bad++; $display("FAIL force_on: got %b want 0100", bus.channel_ready); end
        bus.channel_enable = 4'hB;
        step();
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL force_ready: got %b want 0000", bus.channel_ready); end
        n_cmp++; if (bus.any_clock_on !== 1'b0) begin n_bad++; $display("FAIL force_any: got %b want 0", bus.any_clock_on); end
        n_cmp++; if (bus.gated_clocks !== 4'h4) begin n_bad++; $display("FAIL force_last_edge: got %b want 0100", bus.gated_clocks); end
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL force_closed: got %b want 0000", bus.gated_clocks); end
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL force_stays_off: got %b want 0000", bus.gated_clocks); end
        settle();
    endtask

    task automatic test_all_channels();
        bus.idle_threshold  = 8'd3;
        bus.channel_request = 4'hF;
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL all_k: got %b want 0000", bus.gated_clocks); end
        step();
        n_cmp++; if (bus.gated_clocks !== 4'hF) begin n_bad++; $display("FAIL all_k1: got %b want 1111", bus.gated_clocks); end
        step();
        n_cmp++; if (bus.channel_ready !== 4'hF) begin n_bad++; $display("FAIL all_ready: got %b want 1111", bus.channel_ready); end
        settle();
    endtask

`ifdef CLOCK_GATE_TEST_MODE_EN
    task automatic test_test_mode();
        bus.test_enable = 1'b1;
        step();
        n_cmp++; if (bus.gated_clocks !== 4'hF) begin n_bad++; $display("FAIL tm_gated: got %b want 1111", bus.gated_clocks); end
        n_cmp++; if (bus.channel_ready !== 4'h0) begin n_bad++; $display("FAIL tm_ready: got %b want 0000", bus.channel_ready); end
        n_cmp++; if (bus.any_clock_on !== 1'b0) begin n_bad++; $display("FAIL tm_any: got %b want 0", bus.any_clock_on); end
        bus.test_enable = 1'b0;
        step();
        n_cmp++; if (bus.gated_clocks !== 4'h0) begin n_bad++; $display("FAIL tm_off: got %b want 0000", bus.gated_clocks); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset               = 1'b0;
        bus.channel_enable  = 4'h0;
        bus.channel_request = 4'h0;
        bus.idle_threshold  = 8'd3;
`ifdef CLOCK_GATE_TEST_MODE_EN
        bus.test_enable     = 1'b0;
`endif
        test_reset();
        test_wake();
        test_hold_close();
        test_rerequest();
        test_threshold_zero();
        test_live_threshold();
        test_forced_off();
        test_all_channels();
`ifdef CLOCK_GATE_TEST_MODE_EN
        test_test_mode();
`endif
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
